// File: rtl/seg_sched_pkg.sv
// seg_sched_pkg: shared types and constants for the 7-segment display-ownership
// scheduler (seg_sched) and its optional pending-result FIFO (seg_sched_fifo).

package seg_sched_pkg;

    // Display ownership states
    typedef enum logic [1:0] {
        ST_CNT    = 2'd0,   // counter source owns the display
        ST_HOLD   = 2'd1,   // an OUT result is shown for a limited time
        ST_STICKY = 2'd2    // the OUT view is pinned by the view button
    } state_e;

    // Indicator LED patterns on controll
    localparam logic [7:0] CTRL_CNT    = 8'h01;
    localparam logic [7:0] CTRL_OUT    = 8'h02;
    localparam logic [7:0] CTRL_STICKY = 8'h04;

    // Four digits of segment patterns (output source / latch)
    typedef logic [3:0][7:0] seg4_t;

    // Eight digits of segment patterns (full display)
    typedef logic [7:0][7:0] seg8_t;

    // Indicator pattern shown for a given ownership state
    function automatic logic [7:0] ctrl_for(input state_e st);
        logic [7:0] ctl;
        case (st)
            ST_CNT:    ctl = CTRL_CNT;
            ST_HOLD:   ctl = CTRL_OUT;
            ST_STICKY: ctl = CTRL_STICKY;
            default:   ctl = CTRL_CNT;
        endcase
        return ctl;
    endfunction

    // Output-source view: latched digits 0-3, blank digits 4-7
    function automatic seg8_t out_view(input seg4_t latch);
        seg8_t s;
        s[3:0] = latch;
        s[7:4] = 32'h0000_0000;
        return s;
    endfunction

endpackage

// File: rtl/seg_sched_fifo.sv
// seg_sched_fifo: two-entry FIFO of pending OUT results (seg4_t). Used by
// seg_sched only when SEG_SCHED_QUEUE_EN is defined. flush empties the FIFO
// and takes priority over push/pop. A push while full is accepted only when a
// pop happens in the same cycle.

module seg_sched_fifo
    import seg_sched_pkg::*;
(
    input  logic  clk,
    input  logic  rst_n,
    input  logic  push,
    input  logic  pop,
    input  logic  flush,
    input  seg4_t din,
    output seg4_t dout,
    output logic  full,
    output logic  empty
);

    seg4_t      mem_q [2];
    logic       rd_q;
    logic       wr_q;
    logic [1:0] cnt_q;

    logic do_pop_s;
    logic do_push_s;

    assign full      = (cnt_q == 2'd2);
    assign empty     = (cnt_q == 2'd0);
    assign do_pop_s  = pop && !empty;
    assign do_push_s = push && (!full || do_pop_s);
    assign dout      = mem_q[rd_q];

    // Storage, pointers and occupancy count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            rd_q     <= 1'b0;
            wr_q     <= 1'b0;
            cnt_q    <= 2'd0;
        end else if (flush) begin
            rd_q     <= 1'b0;
            wr_q     <= 1'b0;
            cnt_q    <= 2'd0;
        end else begin
            if (do_push_s) begin
                mem_q[wr_q] <= din;
                wr_q        <= ~wr_q;
            end
            if (do_pop_s) begin
                rd_q <= ~rd_q;
            end
            case ({do_push_s, do_pop_s})
                2'b10:   cnt_q <= cnt_q + 2'd1;
                2'b01:   cnt_q <= cnt_q - 2'd1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule

// File: rtl/seg_sched.sv
// seg_sched: display-ownership scheduler for eight 7-segment digit banks.
// The counter source owns the display until an OUT result arrives; the result
// is held for HOLD_CYCLES cycles and the display then returns to the counter.
// Each rising edge of view_btn toggles a pinned OUT view.
// Optional feature macro: SEG_SCHED_QUEUE_EN adds a 2-entry FIFO of results
// that arrive while one is already being held (without it, a new result
// overwrites the held one and restarts the hold time, and drop stays 0).

module seg_sched
    import seg_sched_pkg::*;
#(
    parameter int HOLD_CYCLES = 50_000_000,
    parameter int CW          = $clog2(HOLD_CYCLES + 1)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [7:0][7:0] seg_cnt,
    input  logic            out_req,
    input  logic [3:0][7:0] out_seg,
    input  logic            view_btn,
    output logic [7:0][7:0] seg,
    output logic [7:0]      controll,
    output logic            out_busy,
    output logic            drop
);

    localparam logic [CW-1:0] TIMER_RELOAD = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] TIMER_ONE    = CW'(1);
    localparam logic [CW-1:0] TIMER_ZERO   = CW'(0);

    state_e          state_q, state_d;
    seg4_t           latch_q, latch_d;
    logic [CW-1:0]   timer_q, timer_d;
    logic            view_q;
    logic            view_rise_s;

    seg8_t           seg_q, seg_d;
    logic [7:0]      controll_q, controll_d;
    logic            out_busy_q, out_busy_d;
    logic            drop_q, drop_d;

`ifdef SEG_SCHED_QUEUE_EN
    logic            q_push_s;
    logic            q_pop_s;
    logic            q_flush_s;
    logic            q_full_s;
    logic            q_empty_s;
    seg4_t           q_dout_s;

    seg_sched_fifo u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (q_push_s),
        .pop   (q_pop_s),
        .flush (q_flush_s),
        .din   (out_seg),
        .dout  (q_dout_s),
        .full  (q_full_s),
        .empty (q_empty_s)
    );
`endif

    assign view_rise_s = view_btn && !view_q;

    // Ownership FSM, latch capture and hold timer next-state
    always_comb begin
        state_d = state_q;
        latch_d = latch_q;
        timer_d = timer_q;
        drop_d  = 1'b0;
`ifdef SEG_SCHED_QUEUE_EN
        q_push_s  = 1'b0;
        q_pop_s   = 1'b0;
        q_flush_s = 1'b0;
`endif
        case (state_q)
            ST_CNT: begin
                if (out_req) begin
                    latch_d = out_seg;
                    timer_d = TIMER_RELOAD;
                    state_d = ST_HOLD;
                end else begin
                    state_d = ST_CNT;
                end
                // A view edge overrides the capture's HOLD target
                if (view_rise_s) begin
                    state_d = ST_STICKY;
                end else begin
                    state_d = state_d;
                end
            end
            ST_HOLD: begin
`ifdef SEG_SCHED_QUEUE_EN
                if (view_rise_s) begin
                    // Pinning abandons queued results; a coincident request
                    // goes straight to the latch as it would in STICKY
                    state_d   = ST_STICKY;
                    q_flush_s = 1'b1;
                    if (out_req) begin
                        latch_d = out_seg;
                    end else begin
                        latch_d = latch_q;
                    end
                end else if (timer_q == TIMER_ZERO) begin
                    if (!q_empty_s) begin
                        // Next queued result takes over; a coincident
                        // request queues behind it if there was room
                        q_pop_s = 1'b1;
                        latch_d = q_dout_s;
                        timer_d = TIMER_RELOAD;
                        if (out_req) begin
                            if (q_full_s) begin
                                drop_d = 1'b1;
                            end else begin
                                q_push_s = 1'b1;
                            end
                        end else begin
                            q_push_s = 1'b0;
                        end
                    end else if (out_req) begin
                        // Empty queue: the new result bypasses it
                        latch_d = out_seg;
                        timer_d = TIMER_RELOAD;
                    end else begin
                        state_d = ST_CNT;
                    end
                end else begin
                    timer_d = timer_q - TIMER_ONE;
                    if (out_req) begin
                        if (q_full_s) begin
                            drop_d = 1'b1;
                        end else begin
                            q_push_s = 1'b1;
                        end
                    end else begin
                        q_push_s = 1'b0;
                    end
                end
`else
                if (out_req) begin
                    // New result overwrites and restarts, even at expiry
                    latch_d = out_seg;
                    timer_d = TIMER_RELOAD;
                end else if (timer_q == TIMER_ZERO) begin
                    state_d = ST_CNT;
                end else begin
                    timer_d = timer_q - TIMER_ONE;
                end
                if (view_rise_s) begin
                    state_d = ST_STICKY;
                end else begin
                    state_d = state_d;
                end
`endif
            end
            ST_STICKY: begin
                if (out_req) begin
                    latch_d = out_seg;
                end else begin
                    latch_d = latch_q;
                end
                if (view_rise_s) begin
                    state_d = ST_CNT;
                end else begin
                    state_d = ST_STICKY;
                end
            end
            default: begin
                state_d = ST_CNT;
            end
        endcase
    end

    // Output drive computed from the next state so outputs lag inputs by one cycle
    always_comb begin
        seg_d      = seg_cnt;
        controll_d = ctrl_for(state_d);
        out_busy_d = (state_d != ST_CNT);
        if (state_d == ST_CNT) begin
            seg_d = seg_cnt;
        end else begin
            seg_d = out_view(latch_d);
        end
    end

    // State, latch, timer and view-button edge detector
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_CNT;
            latch_q <= '0;
            timer_q <= TIMER_ZERO;
            view_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            latch_q <= latch_d;
            timer_q <= timer_d;
            view_q  <= view_btn;
        end
    end

    // Registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_q      <= '0;
            controll_q <= CTRL_CNT;
            out_busy_q <= 1'b0;
            drop_q     <= 1'b0;
        end else begin
            seg_q      <= seg_d;
            controll_q <= controll_d;
            out_busy_q <= out_busy_d;
            drop_q     <= drop_d;
        end
    end

    assign seg      = seg_q;
    assign controll = controll_q;
    assign out_busy = out_busy_q;
    assign drop     = drop_q;

endmodule

// File: doc/seg_sched.md
# seg_sched

Display-ownership scheduler for the board's eight 7-segment digit banks. Sits between the cycle-counter display source and the CPU `OUT` display source, driving the segment buses and the `controll` indicator LEDs. An `OUT` result holds the display for a programmable time and then reverts to the counter. A debounced view button can pin the output view indefinitely.

## Interface
Parameters:
- `HOLD_CYCLES`, default 50_000_000: clock cycles an `OUT` result stays displayed; legal range is 1 or more.
- `CW`, default `$clog2(HOLD_CYCLES+1)`: hold timer width; derived, never overridden.

Ports:
- `clk`  in  1  system clock.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `seg_cnt`  in  [7:0][7:0]  counter-source segment patterns, digits 0–7.
- `out_req`  in  1  single-cycle pulse; capture `out_seg` as a new output result.
- `out_seg`  in  [3:0][7:0]  output-source segment patterns, digits 0–3.
- `view_btn`  in  1  debounced level; each rising edge toggles the pinned view.
- `seg`  out  [7:0][7:0]  registered segment drive, digits 0–7.
- `controll`  out  8  registered indicator LEDs: `8'h01` counter, `8'h02` held output, `8'h04` pinned output.
- `out_busy`  out  1  registered; high while the output view is shown (HOLD or STICKY).
- `drop`  out  1  registered single-cycle pulse when a request is discarded.

## Operation
- Internal state: `latch` (4×8 bits), `timer` (`CW` bits), `view_q` (edge detector), FSM state.
- Display per state:
  - CNT: `seg` shows `seg_cnt`.
  - HOLD and STICKY: digits 0–3 show `latch`; digits 4–7 show 0.
- CNT:
  - `out_req` → `latch`←`out_seg`, `timer`←`HOLD_CYCLES-1`, go to HOLD.
  - View rising edge → STICKY, showing the current `latch` (all 0 after reset).
- HOLD:
  - `timer`==0 → CNT; otherwise `timer` decrements.
  - `out_req` → `latch`←`out_seg` and `timer` restarts at `HOLD_CYCLES-1`. Queue build differs; see Configuration.
  - View rising edge → STICKY.
- STICKY:
  - `out_req` → `latch`←`out_seg`; state stays STICKY.
  - View rising edge → CNT.
- Simultaneous `out_req` and view edge: the capture happens and the view edge decides the next state.
  - From CNT → STICKY, showing the new data.
  - From HOLD → STICKY.
  - From STICKY → CNT, with `latch` updated.
- Simultaneous `out_req` and `timer`==0 in HOLD: the capture wins; state stays HOLD and the timer restarts.
- `HOLD_CYCLES`=1: HOLD lasts exactly one cycle.
- Reset values: state CNT, `seg` all 0, `controll`=`8'h01`, `out_busy`=0, `drop`=0, `latch`=0, `timer`=0, `view_q`=0, queue empty.
- Reset asserted mid-HOLD or mid-STICKY abandons the display immediately; no pending data survives reset.

## Timing
- All outputs are registered; latency is 1 cycle from the input edge to the output.
- `seg_cnt` change at cycle t appears on `seg` at t+1 while in CNT.
- `out_req` at cycle t (from CNT): at t+1, `seg` shows the data, `controll`=`8'h02` and `out_busy`=1.
- Hold length: with `out_req` at t, CNT display returns at t+1+`HOLD_CYCLES`.
- View edge: `view_btn` low at t-1 and high at t gives the state change visible at t+1. Held-high `view_btn` causes no further toggles.

## Configuration
- `SEG_SCHED_QUEUE_EN` defined: adds a 2-entry FIFO of pending results.
  - `out_req` in HOLD enqueues `out_seg` and does not restart the timer.
  - At timer expiry with the queue non-empty: pop into `latch`, restart the timer, stay HOLD.
  - `out_req` with the queue full → data discarded and `drop` pulses at t+1.
  - Enqueue and pop in the same cycle are both honoured.
  - Entering STICKY flushes the queue; in STICKY, `out_req` writes `latch` directly.
- Not defined: no queue; HOLD overwrite-and-restart behaviour as in Operation; `drop` is constant 0.

## Structure
- `seg_sched_pkg` holds:
  - the state enum (`ST_CNT`, `ST_HOLD`, `ST_STICKY`);
  - constants `CTRL_CNT`=`8'h01`, `CTRL_OUT`=`8'h02`, `CTRL_STICKY`=`8'h04`;
  - typedef `seg4_t` = `logic [3:0][7:0]`.
- Sub-module `seg_sched_fifo`: 2-entry `seg4_t` FIFO with `push`/`pop`/`full`/`empty`/`flush`. Instantiated only under `SEG_SCHED_QUEUE_EN`.

## Test plan
- Release reset with `seg_cnt`=`8'h3F` on all digits → at the next cycle `seg` digits=`8'h3F`, `controll`=`8'h01`; during reset all outputs are 0 except `controll`=`8'h01`.
- `HOLD_CYCLES`=4, `out_req` at t with `out_seg`={`8'h06`,`8'h5B`,`8'h4F`,`8'h66`} → cycles t+1..t+4: digits 0–3 show the data, 4–7 show 0, `controll`=`8'h02`, `out_busy`=1; at t+5 counter display with `controll`=`8'h01`.
- `HOLD_CYCLES`=4, second `out_req` at t+2 (no macro) → new data shown at t+3, CNT returns at t+7.
- `view_btn` rising edge in CNT → `controll`=`8'h04` indefinitely; `out_req` updates digits; second rising edge → CNT.
- With `SEG_SCHED_QUEUE_EN`, `HOLD_CYCLES`=4: `out_req` at t, t+1, t+2, t+3 → results A, B, C each shown 4 cycles in order; D discarded with `drop`=1 at t+4.
- Assert `rst_n` low mid-HOLD → outputs go to reset values asynchronously; after release, CNT display, no residual data.
